// File: rtl/uart_autobaud_pkg.sv
// Shared types and constants for the UART auto-baud calibration block.
// State encoding, sync-character constants and the settings word layout.
package uart_autobaud_pkg;

  localparam int unsigned DELAYFRAMES_W = 8;

  // One-hot calibration FSM states
  localparam logic [4:0] AB_STATE_IDLE    = 5'b00001;
  localparam logic [4:0] AB_STATE_QUIET   = 5'b00010;
  localparam logic [4:0] AB_STATE_ARMED   = 5'b00100;
  localparam logic [4:0] AB_STATE_MEASURE = 5'b01000;
  localparam logic [4:0] AB_STATE_CHECK   = 5'b10000;

  localparam logic [7:0]  AUTOBAUD_SYNC_CHAR  = 8'h55;
  localparam int unsigned AUTOBAUD_FALL_EDGES = 5;

  // UART settings word shared by uart_rx / uart_tx
  typedef struct packed {
    logic [1:0]               parity;
    logic                     stopbits;
    logic [1:0]               databits;
    logic [DELAYFRAMES_W-1:0] delayframes;
  } uart_settings_t;

endpackage

// File: rtl/uart_autobaud_if.sv
// Host/UART-facing handshake and settings bus of the auto-baud block.
interface uart_autobaud_if;
  import uart_autobaud_pkg::*;

  logic           start;
  uart_settings_t base_settings;
  uart_settings_t settings_out;
  logic           locked;
  logic           busy;
  logic           cal_error;

  modport master (
    output start, base_settings,
    input  settings_out, locked, busy, cal_error
  );

  modport slave (
    input  start, base_settings,
    output settings_out, locked, busy, cal_error
  );

endinterface

// File: rtl/uart_edge_timer.sv
// rx pin synchronizer, ce-qualified edge detect, saturating measurement
// counter with overflow flag, and falling-edge counter.
module uart_edge_timer #(
  parameter int unsigned MEAS_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              rxpin,
  input  logic              clear,
  input  logic              run,
  output logic              line,
  output logic              fall_c,
  output logic              rise_c,
  output logic [MEAS_W-1:0] meas,
  output logic              ovf,
  output logic [2:0]        fall_cnt
);

  logic [1:0] sync_q;
  logic       prev_q;

  // Two-flop synchronizer, idles high like the line
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rxpin};
  end

  assign line = sync_q[1];

  // Previous line value sampled only on ce ticks so edges land on a tick
  always_ff @(posedge clk) begin
    if (rst)     prev_q <= 1'b1;
    else if (ce) prev_q <= line;
  end

  assign fall_c = ce & prev_q & ~line;
  assign rise_c = ce & ~prev_q & line;

  // Measurement counter saturates and flags overflow instead of wrapping
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      meas     <= '0;
      ovf      <= 1'b0;
      fall_cnt <= '0;
    end else if (run && ce) begin
      if (&meas) ovf  <= 1'b1;
      else       meas <= meas + MEAS_W'(1);
      if (fall_c) fall_cnt <= fall_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/uart_autobaud.sv
// Baud-rate calibration controller: waits for a quiet line, times the
// sync character 0x55 and publishes a settings word with DELAYFRAMES set.
// Optional: UART_AUTOBAUD_RANGE_CHECK_EN rejects characters whose start
// bit deviates from the mean bit period by more than 25%.
module uart_autobaud
  import uart_autobaud_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = DELAYFRAMES_W,
  parameter int unsigned IDLE_TICKS    = 64,
  parameter int unsigned MIN_PERIOD    = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           uart_rxpin,
  uart_autobaud_if.slave bus
);

  localparam int unsigned MEAS_W    = COUNTER_WIDTH + 4;
  localparam int unsigned PERIOD_W  = MEAS_W - 2;
  localparam int unsigned QUIET_W   = $clog2(IDLE_TICKS + 1);
  localparam int unsigned FALL_LAST = AUTOBAUD_FALL_EDGES - 2;

  logic [4:0]          state, state_nxt;
  logic [QUIET_W-1:0]  quiet, quiet_nxt;
  logic [MEAS_W-1:0]   total, total_nxt;
  uart_settings_t      base_q, base_nxt;
  uart_settings_t      settings_q, settings_nxt;
  logic                locked_q, locked_nxt;
  logic                err_q, err_nxt;
  logic                busy_q;
  logic                clear, run;
  logic                line, fall_c, rise_c, ovf;
  logic [MEAS_W-1:0]   meas;
  logic [2:0]          fall_cnt;
  logic [PERIOD_W-1:0] period;
  logic                bad;

  uart_edge_timer #(.MEAS_W(MEAS_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .rxpin    (uart_rxpin),
    .clear    (clear),
    .run      (run),
    .line     (line),
    .fall_c   (fall_c),
    .rise_c   (rise_c),
    .meas     (meas),
    .ovf      (ovf),
    .fall_cnt (fall_cnt)
  );

`ifdef UART_AUTOBAUD_RANGE_CHECK_EN
  localparam int unsigned RW = MEAS_W + 4;
  logic [MEAS_W-1:0] start_w, start_w_nxt;
  logic              rise_seen, rise_seen_nxt;
  logic [RW-1:0]     sw8, tot_r, dev;
  logic              range_bad;

  // Deviation of 8x start-bit width from the 8-bit total
  always_comb begin
    sw8       = {1'b0, start_w, 3'b000};
    tot_r     = RW'(total);
    dev       = (sw8 >= tot_r) ? (sw8 - tot_r) : (tot_r - sw8);
    range_bad = dev > RW'(total >> 2);
  end
`else
  logic unused_rise;
  assign unused_rise = rise_c;
`endif

  // Rounded bit period and acceptance test for the CHECK state
  always_comb begin
    period = PERIOD_W'(({1'b0, total} + (MEAS_W + 1)'(4)) >> 3);
    bad    = ovf
           | (period < PERIOD_W'(MIN_PERIOD))
           | (period > PERIOD_W'(2 ** COUNTER_WIDTH));
`ifdef UART_AUTOBAUD_RANGE_CHECK_EN
    bad = bad | range_bad;
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    quiet_nxt    = quiet;
    total_nxt    = total;
    base_nxt     = base_q;
    settings_nxt = settings_q;
    locked_nxt   = locked_q;
    err_nxt      = 1'b0;
    clear        = 1'b0;
    run          = 1'b0;
`ifdef UART_AUTOBAUD_RANGE_CHECK_EN
    start_w_nxt   = start_w;
    rise_seen_nxt = rise_seen;
`endif
    case (state)
      AB_STATE_IDLE: begin
        if (bus.start) begin
          state_nxt  = AB_STATE_QUIET;
          base_nxt   = bus.base_settings;
          locked_nxt = 1'b0;
          quiet_nxt  = '0;
        end
      end
      AB_STATE_QUIET: begin
        if (quiet == QUIET_W'(IDLE_TICKS)) state_nxt = AB_STATE_ARMED;
        else if (ce) quiet_nxt = line ? (quiet + QUIET_W'(1)) : '0;
      end
      AB_STATE_ARMED: begin
        if (fall_c) begin
          state_nxt = AB_STATE_MEASURE;
          clear     = 1'b1;
`ifdef UART_AUTOBAUD_RANGE_CHECK_EN
          rise_seen_nxt = 1'b0;
`endif
        end
      end
      AB_STATE_MEASURE: begin
        run = 1'b1;
        if (ovf) begin
          state_nxt = AB_STATE_CHECK;
        end else if (fall_c && (fall_cnt == 3'(FALL_LAST))) begin
          total_nxt = meas;
          state_nxt = AB_STATE_CHECK;
        end
`ifdef UART_AUTOBAUD_RANGE_CHECK_EN
        if (rise_c && !rise_seen) begin
          start_w_nxt   = meas;
          rise_seen_nxt = 1'b1;
        end
`endif
      end
      AB_STATE_CHECK: begin
        state_nxt = AB_STATE_IDLE;
        if (bad) begin
          err_nxt = 1'b1;
        end else begin
          settings_nxt             = base_q;
          settings_nxt.delayframes = DELAYFRAMES_W'(period - PERIOD_W'(1));
          locked_nxt               = 1'b1;
        end
      end
      default: state_nxt = AB_STATE_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= AB_STATE_IDLE;
      quiet      <= '0;
      total      <= '0;
      base_q     <= '0;
      settings_q <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_AUTOBAUD_RANGE_CHECK_EN
      start_w    <= '0;
      rise_seen  <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      quiet      <= quiet_nxt;
      total      <= total_nxt;
      base_q     <= base_nxt;
      settings_q <= settings_nxt;
      locked_q   <= locked_nxt;
      err_q      <= err_nxt;
      busy_q     <= (state_nxt != AB_STATE_IDLE);
`ifdef UART_AUTOBAUD_RANGE_CHECK_EN
      start_w    <= start_w_nxt;
      rise_seen  <= rise_seen_nxt;
`endif
    end
  end

  assign bus.settings_out = settings_q;
  assign bus.locked       = locked_q;
  assign bus.busy         = busy_q;
  assign bus.cal_error    = err_q;

endmodule
